// File: rtl/ysyx_24080014_lsu.sv
`default_nettype none
// ============================================================================
// ysyx_24080014_lsu : load/store unit, one outstanding access on a valid/ready
//                     data bus, with misalign/illegal/timeout error reporting.
// Revision: 1.0
// ============================================================================
module ysyx_24080014_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  mem_op,
  input  logic        mem_wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] read_data,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_wen,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic        bus_rsp_err,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [2:0]  r_op;
  logic        r_wen;
  logic [1:0]  r_off;
  logic [7:0]  r_cnt;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_read_data;
  logic        r_bus_req_valid;
  logic [31:0] r_bus_addr;
  logic        r_bus_wen;
  logic [3:0]  r_bus_wstrb;
  logic [31:0] r_bus_wdata;

  logic        w_accept;
  logic        w_illegal;
  logic        w_misal;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  assign w_accept = req_valid && r_req_ready;

  // Stores only have sb/sh/sw; loads additionally allow lbu/lhu.
  assign w_illegal = mem_wen ? (mem_op[2] || (mem_op[1:0] == 2'b11))
                             : ((mem_op == 3'b011) || (mem_op[2:1] == 2'b11));

  assign w_misal = ((mem_op[1:0] == 2'b01) && addr[0]) ||
                   ((mem_op[1:0] == 2'b10) && (addr[1:0] != 2'b00));

  always_comb begin
    w_strb  = 4'b0000;
    w_wdata = wdata;
    if (mem_wen) begin
      case (mem_op[1:0])
        2'b00: begin
          w_strb  = 4'b0001 << addr[1:0];
          w_wdata = {4{wdata[7:0]}};
        end
        2'b01: begin
          w_strb  = 4'b0011 << addr[1:0];
          w_wdata = {2{wdata[15:0]}};
        end
        default: w_strb = 4'b1111;
      endcase
    end
  end

  always_comb begin
    w_byte = bus_rdata[7:0];
    case (r_off)
      2'd1:    w_byte = bus_rdata[15:8];
      2'd2:    w_byte = bus_rdata[23:16];
      2'd3:    w_byte = bus_rdata[31:24];
      default: w_byte = bus_rdata[7:0];
    endcase
    w_half = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (r_op)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_op            <= 3'd0;
      r_wen           <= 1'b0;
      r_off           <= 2'd0;
      r_cnt           <= 8'd0;
      r_req_ready     <= 1'b1;
      r_resp_valid    <= 1'b0;
      r_resp_err      <= 1'b0;
      r_read_data     <= 32'd0;
      r_bus_req_valid <= 1'b0;
      r_bus_addr      <= 32'd0;
      r_bus_wen       <= 1'b0;
      r_bus_wstrb     <= 4'd0;
      r_bus_wdata     <= 32'd0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op        <= mem_op;
            r_wen       <= mem_wen;
            r_off       <= addr[1:0];
            r_req_ready <= 1'b0;
            if (w_illegal || w_misal) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_read_data  <= 32'd0;
            end else begin
              r_state         <= S_REQ;
              r_bus_req_valid <= 1'b1;
              r_bus_addr      <= {addr[31:2], 2'b00};
              r_bus_wen       <= mem_wen;
              r_bus_wstrb     <= w_strb;
              r_bus_wdata     <= w_wdata;
            end
          end
        end
        S_REQ: begin
          if (bus_req_ready) begin
            r_bus_req_valid <= 1'b0;
            r_cnt           <= 8'd0;
            r_state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus_rsp_valid) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= bus_rsp_err;
            r_read_data  <= (!r_wen && !bus_rsp_err) ? w_ext : 32'd0;
          end else if (r_cnt == c_TO_LAST) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_read_data  <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_resp_err  <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign resp_valid    = r_resp_valid;
  assign resp_err      = r_resp_err;
  assign read_data     = r_read_data;
  assign bus_req_valid = r_bus_req_valid;
  assign bus_addr      = r_bus_addr;
  assign bus_wen       = r_bus_wen;
  assign bus_wstrb     = r_bus_wstrb;
  assign bus_wdata     = r_bus_wdata;

endmodule
`default_nettype wire
